// File: rtl/pin_route_pkg.sv
// Shared types and pin-group indices for the pin routing sequencer.
package pin_route_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2,
      SETTLE = 2'd3
   } route_state_t;

   localparam int GRP_PS2   = 0;
   localparam int GRP_VGA   = 1;
   localparam int GRP_AUDIO = 2;
   localparam int GRP_UART  = 3;

endpackage

// File: rtl/pin_route_sequencer_guard_timer.sv
// Load/decrement guard counter with zero flag, shared by the drain and settle phases.
`default_nettype none
module route_guard_timer #(
   parameter int WIDTH = 7
) (
   input  logic             clock,
   input  logic             nres,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clock or negedge nres) begin
      if (!nres) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pin_route_sequencer.sv
// Break-before-make sequencer for board pin routing muxes.
// Optional core reset request on RESET_GROUP changes: define PIN_ROUTE_CORE_RESET_EN.
`default_nettype none
module pin_route_sequencer
   import pin_route_pkg::*;
#(
   parameter int NUM_GROUPS   = 4,
   parameter int GUARD_CYCLES = 64,
   parameter int RESET_GROUP  = GRP_UART
) (
   input  logic                  clock,
   input  logic                  nres,
   input  logic [NUM_GROUPS-1:0] sel_req,
   input  logic                  freeze,
   output logic [NUM_GROUPS-1:0] sel_active,
   output logic [NUM_GROUPS-1:0] group_hiz,
   output logic                  busy,
   output logic [7:0]            change_count,
   output logic                  core_res_req
);

   localparam int CNT_W = $clog2(GUARD_CYCLES + 1);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

   if ((RESET_GROUP < 0) || (RESET_GROUP >= NUM_GROUPS) || (GUARD_CYCLES < 1)) begin : g_param_check
      $error("pin_route_sequencer: RESET_GROUP or GUARD_CYCLES out of range");
   end

   route_state_t          state_q;
   logic [NUM_GROUPS-1:0] pending_q;
   logic [NUM_GROUPS-1:0] sel_active_q;
   logic [NUM_GROUPS-1:0] group_hiz_q;
   logic                  busy_q;
   logic [7:0]            change_count_q;
   logic                  core_res_req_q;

   logic tmr_load;
   logic tmr_dec;
   logic tmr_zero;
   logic crr_set;

`ifdef PIN_ROUTE_CORE_RESET_EN
   assign crr_set = (pending_q[RESET_GROUP] != sel_active_q[RESET_GROUP]);
`else
   assign crr_set = 1'b0;
`endif

   // Timer controls mirror the FSM branches so the counter and state stay in lockstep.
   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      case (state_q)
         IDLE:   tmr_load = !freeze && (sel_req != sel_active_q);
         DRAIN: begin
            if (sel_req != pending_q) begin
               tmr_load = 1'b1;
            end else if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end
         end
         COMMIT: tmr_load = 1'b1;
         SETTLE: tmr_dec  = !tmr_zero;
         default: ;
      endcase
   end

   route_guard_timer #(
      .WIDTH(CNT_W)
   ) u_timer (
      .clock      (clock),
      .nres       (nres),
      .load_i     (tmr_load),
      .dec_i      (tmr_dec),
      .load_val_i (GUARD_LOAD),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clock or negedge nres) begin
      if (!nres) begin
         state_q        <= IDLE;
         pending_q      <= '0;
         sel_active_q   <= '0;
         group_hiz_q    <= '0;
         busy_q         <= 1'b0;
         change_count_q <= '0;
         core_res_req_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!freeze && (sel_req != sel_active_q)) begin
                  pending_q   <= sel_req;
                  group_hiz_q <= sel_req ^ sel_active_q;
                  busy_q      <= 1'b1;
                  state_q     <= DRAIN;
               end
            end
            DRAIN: begin
               // Hi-Z set only ever widens so a group already floated stays floated.
               if (sel_req != pending_q) begin
                  pending_q   <= sel_req;
                  group_hiz_q <= group_hiz_q | (sel_req ^ sel_active_q);
               end else if (tmr_zero) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               sel_active_q <= pending_q;
               if ((pending_q != sel_active_q) && (change_count_q != 8'hFF)) begin
                  change_count_q <= change_count_q + 8'd1;
               end
               if (crr_set) begin
                  core_res_req_q <= 1'b1;
               end
               state_q <= SETTLE;
            end
            SETTLE: begin
               if (tmr_zero) begin
                  group_hiz_q    <= '0;
                  core_res_req_q <= 1'b0;
                  busy_q         <= 1'b0;
                  state_q        <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sel_active   = sel_active_q;
   assign group_hiz    = group_hiz_q;
   assign busy         = busy_q;
   assign change_count = change_count_q;
   assign core_res_req = core_res_req_q;

endmodule
`default_nettype wire

// File: tb/tb_pin_route_sequencer.sv
// Self-checking bench for pin_route_sequencer with GUARD_CYCLES=4.
`default_nettype none
module tb_pin_route_sequencer;

   localparam int NG = 4;
   localparam int GC = 4;
`ifdef PIN_ROUTE_CORE_RESET_EN
   localparam logic CRR_EN = 1'b1;
`else
   localparam logic CRR_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          nres  = 1'b0;
   logic [NG-1:0] sel_req = '0;
   logic          freeze  = 1'b0;
   logic [NG-1:0] sel_active;
   logic [NG-1:0] group_hiz;
   logic          busy;
   logic [7:0]    change_count;
   logic          core_res_req;

   always #5 clock = ~clock;

   pin_route_sequencer #(
      .NUM_GROUPS   (NG),
      .GUARD_CYCLES (GC),
      .RESET_GROUP  (3)
   ) dut (
      .clock        (clock),
      .nres         (nres),
      .sel_req      (sel_req),
      .freeze       (freeze),
      .sel_active   (sel_active),
      .group_hiz    (group_hiz),
      .busy         (busy),
      .change_count (change_count),
      .core_res_req (core_res_req)
   );

   typedef struct {
      logic          rst;
      logic [NG-1:0] req;
      logic          frz;
      int            reps;
      logic [NG-1:0] act;
      logic [NG-1:0] hiz;
      logic          bsy;
      logic [7:0]    cnt;
      logic          crr;
   } vec_t;

   typedef struct {
      logic [NG-1:0] act;
      logic [NG-1:0] hiz;
      logic          bsy;
      logic [7:0]    cnt;
      logic          crr;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic rst, input logic [NG-1:0] req, input logic frz, input int reps,
                      input logic [NG-1:0] act, input logic [NG-1:0] hiz, input logic bsy,
                      input logic [7:0] cnt, input logic crr);
      vec_t v;
      v.rst = rst; v.req = req; v.frz = frz; v.reps = reps;
      v.act = act; v.hiz = hiz; v.bsy = bsy; v.cnt = cnt; v.crr = crr;
      tbl.push_back(v);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_act"}, 8'(sel_active), 8'h00);
      chk({tag, "_hiz"}, 8'(group_hiz), 8'h00);
      chk({tag, "_busy"}, 8'(busy), 8'h00);
      chk({tag, "_cnt"}, change_count, 8'h00);
      chk({tag, "_crr"}, 8'(core_res_req), 8'h00);
   endtask

   // Called and returns at a falling edge.
   task automatic do_reset();
      nres    = 1'b0;
      sel_req = '0;
      freeze  = 1'b0;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clock);
      nres = 1'b1;
   endtask

   task automatic run_rows(input int lo, input int hi);
      exp_t e;
      exp_t g;
      for (int i = lo; i < hi; i++) begin
         if (tbl[i].rst) do_reset();
         for (int r = 0; r < tbl[i].reps; r++) begin
            sel_req = tbl[i].req;
            freeze  = tbl[i].frz;
            e.act = tbl[i].act; e.hiz = tbl[i].hiz; e.bsy = tbl[i].bsy;
            e.cnt = tbl[i].cnt; e.crr = tbl[i].crr & CRR_EN;
            sb.push_back(e);
            @(posedge clock);
            #1;
            g = sb.pop_front();
            chk($sformatf("row%0d_act", i), 8'(sel_active), 8'(g.act));
            chk($sformatf("row%0d_hiz", i), 8'(group_hiz), 8'(g.hiz));
            chk($sformatf("row%0d_busy", i), 8'(busy), 8'(g.bsy));
            chk($sformatf("row%0d_cnt", i), change_count, g.cnt);
            chk($sformatf("row%0d_crr", i), 8'(core_res_req), 8'(g.crr));
            @(negedge clock);
         end
      end
   endtask

   int seg_a;
   int seg_b;
   int seg_c;
   int n;

   initial begin
      // 1: idle after reset
      add(1, 4'b0000, 0, 50, 4'b0000, 4'b0000, 0, 8'd0, 0);
      // 2: single change 0000->0010
      add(0, 4'b0010, 0, 5,  4'b0000, 4'b0010, 1, 8'd0, 0);
      add(0, 4'b0010, 0, 4,  4'b0010, 4'b0010, 1, 8'd1, 0);
      add(0, 4'b0010, 0, 2,  4'b0010, 4'b0000, 0, 8'd1, 0);
      // 3: request widened mid-drain, single commit
      add(1, 4'b0001, 0, 2,  4'b0000, 4'b0001, 1, 8'd0, 0);
      add(0, 4'b1001, 0, 5,  4'b0000, 4'b1001, 1, 8'd0, 0);
      add(0, 4'b1001, 0, 4,  4'b1001, 4'b1001, 1, 8'd1, 1);
      add(0, 4'b1001, 0, 2,  4'b1001, 4'b0000, 0, 8'd1, 0);
      // 4: request reverts during drain, no-op commit
      add(1, 4'b0100, 0, 1,  4'b0000, 4'b0100, 1, 8'd0, 0);
      add(0, 4'b0000, 0, 9,  4'b0000, 4'b0100, 1, 8'd0, 0);
      add(0, 4'b0000, 0, 2,  4'b0000, 4'b0000, 0, 8'd0, 0);
      // 5: freeze holds off start, ignored mid-sequence; change during settle is queued
      add(0, 4'b1000, 1, 20, 4'b0000, 4'b0000, 0, 8'd0, 0);
      add(0, 4'b1000, 0, 5,  4'b0000, 4'b1000, 1, 8'd0, 0);
      add(0, 4'b1000, 1, 1,  4'b1000, 4'b1000, 1, 8'd1, 1);
      add(0, 4'b0000, 0, 3,  4'b1000, 4'b1000, 1, 8'd1, 1);
      add(0, 4'b0000, 0, 1,  4'b1000, 4'b0000, 0, 8'd1, 0);
      add(0, 4'b0000, 0, 1,  4'b1000, 4'b1000, 1, 8'd1, 0);
      add(0, 4'b0000, 0, 4,  4'b1000, 4'b1000, 1, 8'd1, 0);
      add(0, 4'b0000, 0, 4,  4'b0000, 4'b1000, 1, 8'd2, 1);
      add(0, 4'b0000, 0, 2,  4'b0000, 4'b0000, 0, 8'd2, 0);
      seg_a = tbl.size();
      // 6: fresh sequence after asynchronous abort
      add(0, 4'b1000, 0, 5,  4'b0000, 4'b1000, 1, 8'd0, 0);
      add(0, 4'b1000, 0, 4,  4'b1000, 4'b1000, 1, 8'd1, 1);
      add(0, 4'b1000, 0, 2,  4'b1000, 4'b0000, 0, 8'd1, 0);
      seg_b = tbl.size();
      seg_c = seg_b;

      @(negedge clock);
      run_rows(0, seg_a);

      // Asynchronous reset in the middle of DRAIN
      do_reset();
      sel_req = 4'b1000;
      @(posedge clock);
      @(posedge clock);
      #3;
      chk("pre_abort_busy", 8'(busy), 8'h01);
      nres = 1'b0;
      #1;
      check_zero("abort");
      @(negedge clock);
      nres = 1'b1;
      run_rows(seg_a, seg_b);

      // change_count saturation
      do_reset();
      for (int k = 0; k < 256; k++) begin
         sel_req = (k % 2 == 0) ? 4'b0001 : 4'b0000;
         @(posedge clock);
         #1;
         n = 0;
         while (busy !== 1'b0 && n < 30) begin
            @(posedge clock);
            #1;
            n++;
         end
         if (n >= 30) begin
            chk("sat_timeout_busy", 8'(busy), 8'h00);
            break;
         end
         if (k >= 253) chk($sformatf("sat_cnt_%0d", k), change_count, 8'((k + 1 > 255) ? 255 : k + 1));
         @(negedge clock);
      end

      if (sb.size() != seg_c - seg_b) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pin_route_sequencer.md
Name: pin_route_sequencer

Overview:
- Break-before-make sequencer for the board-level Propeller pin routing muxes: PS/2, VGA/pmodC, audio/pmodB and USB-UART/prop-plug.
- Takes debounced route-select requests and tri-states every affected pin group for a guard interval. It then commits the new select and holds Z for a settle interval before releasing.
- Prevents the core and external pads from driving against each other while routing is being swapped.

Parameters:
- NUM_GROUPS, 4, number of independently routed pin groups.
- GUARD_CYCLES, 64, length of the drain interval and of the settle interval in clock cycles; minimum 1.
- RESET_GROUP, 3, group index whose route change requests a core reset (used only with the optional feature).

Ports:
- clock  in  1  sequencer clock (slow_clk domain).
- nres  in  1  asynchronous active-low reset.
- sel_req  in  NUM_GROUPS  requested route per group, debounced (bit0 PS/2, bit1 VGA, bit2 audio, bit3 UART).
- freeze  in  1  while high, no new change sequence starts.
- sel_active  out  NUM_GROUPS  committed route selects that drive the top-level muxes.
- group_hiz  out  NUM_GROUPS  forces every output of the group to Z in both routes.
- busy  out  1  high whenever state is not IDLE.
- change_count  out  8  saturating count of effective commits.
- core_res_req  out  1  core reset request; see Optional Feature.

Behaviour:
- Reset is asynchronous, active-low, on nres. All outputs are registered.
- Reset values: state IDLE, sel_active=0, group_hiz=0, busy=0, change_count=0, core_res_req=0, pending=0, counter=0.
- Reset mid-sequence aborts immediately to these values. After release, any sel_req≠0 starts a fresh sequence.
- FSM states: IDLE, DRAIN, COMMIT, SETTLE. The counter width is $clog2(GUARD_CYCLES+1).
- IDLE, when freeze=0 and sel_req≠sel_active:
  - pending<=sel_req;
  - group_hiz<=sel_req^sel_active;
  - counter<=GUARD_CYCLES-1;
  - go to DRAIN.
- IDLE otherwise: hold.
- DRAIN, when sel_req≠pending:
  - pending<=sel_req;
  - group_hiz<=group_hiz|(sel_req^sel_active), i.e. only widened, never narrowed;
  - counter reloads to GUARD_CYCLES-1.
- DRAIN, when counter==0: go to COMMIT.
- DRAIN otherwise: decrement counter.
- freeze is ignored once a sequence has started.
- COMMIT:
  - sel_active<=pending;
  - if pending≠sel_active, change_count<=change_count+1, saturating at 255;
  - counter<=GUARD_CYCLES-1;
  - go to SETTLE.
- SETTLE: sel_req changes are ignored. Decrement the counter; at 0, group_hiz<=0 and go to IDLE.
- Timing for a sel_req change sampled at edge N:
  - group_hiz valid after edge N;
  - sel_active updates at edge N+GUARD_CYCLES+1;
  - group_hiz clears and busy falls at edge N+2*GUARD_CYCLES+1.
- A request that reverts to sel_active during DRAIN still completes a full drain and settle. The commit is a no-op and change_count is unchanged.
- Changes queued during SETTLE are picked up in IDLE on the next cycle.

Optional Feature:
- Macro: PIN_ROUTE_CORE_RESET_EN.
- Defined: if a commit changes bit RESET_GROUP of sel_active, core_res_req rises at the COMMIT edge. It falls on the same edge that group_hiz clears.
- Not defined: core_res_req is tied to 0 and RESET_GROUP is unused.

Decomposition:
- Package pin_route_pkg holds:
  - route_state_t enum {IDLE, DRAIN, COMMIT, SETTLE};
  - group index constants GRP_PS2=0, GRP_VGA=1, GRP_AUDIO=2, GRP_UART=3.
- One sub-module, route_guard_timer: load / decrement counter with a zero flag, instantiated once and shared by DRAIN and SETTLE.

Test Plan (GUARD_CYCLES=4):
1. Reset with sel_req=0000: all outputs 0, busy=0, no activity over 50 cycles.
2. sel_req 0000→0010:
   - group_hiz=0010 the next cycle;
   - sel_active=0010 five edges after sampling;
   - group_hiz=0000 and busy=0 nine edges after;
   - change_count=1.
3. sel_req→0001, then →1001 two cycles later in DRAIN:
   - group_hiz=1001 and the drain restarts;
   - sel_active goes directly 0000→1001 in a single commit;
   - change_count increments by exactly 1.
4. sel_req→0100, then back to 0000 during DRAIN:
   - a full drain and settle still occur with group_hiz=0100;
   - sel_active stays 0000 and change_count is unchanged.
5. freeze=1 while sel_req→1000: busy stays 0 for 20 cycles. Release freeze: group_hiz=1000 the next cycle.
6. Reset and optional feature:
   - nres low mid-DRAIN: outputs return to reset values asynchronously;
   - after release with sel_req=1000 and PIN_ROUTE_CORE_RESET_EN defined, core_res_req is high from the COMMIT edge until group_hiz clears;
   - with the macro undefined, core_res_req stays 0.
